// File: rtl/voq_pkt_cnt_array_pkg.sv
// voq_pkt_cnt_array_pkg: shared sizing defaults and helpers for the VOQ packet counter array
package voq_pkt_cnt_array_pkg;

    localparam int PORT_NUB_TOTAL = 8;
    localparam int CNT_WIDTH_DEF  = 9;
    localparam int AFULL_TH_DEF   = 448;

    // Queue-select width; a single queue still gets a 1-bit select.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/voq_pkt_cnt_array_if.sv
// voq_pkt_cnt_array_if: strobe, select and status bundle of the VOQ counter array
interface voq_pkt_cnt_array_if
    import voq_pkt_cnt_array_pkg::*;
#(
    parameter int PORT_NUB  = PORT_NUB_TOTAL,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);

    localparam int WIDTH_SEL = sel_w(PORT_NUB);

    logic [PORT_NUB-1:0]  cnt_add;
    logic                 cnt_minus;
    logic [WIDTH_SEL-1:0] minus_sel;
    logic                 clr;
    logic [WIDTH_SEL-1:0] clr_sel;
    logic                 err_clr;
    logic [WIDTH_SEL-1:0] rd_sel;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [PORT_NUB-1:0]  cnt_eq_zero;
    logic [PORT_NUB-1:0]  cnt_full;
    logic [PORT_NUB-1:0]  cnt_afull;
    logic [PORT_NUB-1:0]  err_ovf;
    logic [PORT_NUB-1:0]  err_udf;

    modport master (
        output cnt_add, cnt_minus, minus_sel, clr, clr_sel, err_clr, rd_sel,
        input  rd_cnt, cnt_eq_zero, cnt_full, cnt_afull, err_ovf, err_udf
    );

    modport slave (
        input  cnt_add, cnt_minus, minus_sel, clr, clr_sel, err_clr, rd_sel,
        output rd_cnt, cnt_eq_zero, cnt_full, cnt_afull, err_ovf, err_udf
    );

endinterface

// File: rtl/voq_pkt_cnt_array_cell.sv
// voq_cnt_cell: one saturating packet counter with level flags and sticky over/underflow bits
module voq_cnt_cell
    import voq_pkt_cnt_array_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int AFULL_TH  = AFULL_TH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 add_i,
    input  logic                 minus_i,
    input  logic                 clr_i,
    input  logic                 err_clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 eq_zero_o,
    output logic                 full_o,
    output logic                 afull_o,
    output logic                 ovf_o,
    output logic                 udf_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d, udf_q, udf_d;
    logic                 inc, dec;

    // Clear beats everything, simultaneous add+minus cancel, otherwise saturate or step.
    always_comb begin
        inc   = add_i && !minus_i && !clr_i;
        dec   = minus_i && !add_i && !clr_i;
        cnt_d = clr_i ? '0 :
                (inc && cnt_q != CNT_MAX) ? cnt_q + CNT_WIDTH'(1) :
                (dec && cnt_q != '0) ? cnt_q - CNT_WIDTH'(1) : cnt_q;
        ovf_d = (inc && cnt_q == CNT_MAX) || (ovf_q && !err_clr_i);
        udf_d = (dec && cnt_q == '0) || (udf_q && !err_clr_i);
    end

    // Counter and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign eq_zero_o = cnt_q == '0;
    assign full_o    = cnt_q == CNT_MAX;
    assign afull_o   = cnt_q >= CNT_WIDTH'(AFULL_TH);
    assign ovf_o     = ovf_q;
    assign udf_o     = udf_q;

endmodule

// File: rtl/voq_pkt_cnt_array.sv
// voq_pkt_cnt_array: per-destination VOQ packet counters with status flags and registered readback
module voq_pkt_cnt_array
    import voq_pkt_cnt_array_pkg::*;
#(
    parameter int PORT_NUB  = PORT_NUB_TOTAL,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int AFULL_TH  = AFULL_TH_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    voq_pkt_cnt_array_if.slave  bus
);

    localparam int WIDTH_SEL = sel_w(PORT_NUB);

    logic [CNT_WIDTH-1:0] cnt_w [PORT_NUB];
    logic [PORT_NUB-1:0]  minus_w, clr_w, eq_w, full_w, afull_w, ovf_w, udf_w;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

    // Out-of-range selects match no queue, so they are naturally ignored.
    for (genvar i = 0; i < PORT_NUB; i++) begin : g_cell
        assign minus_w[i] = bus.cnt_minus && bus.minus_sel == WIDTH_SEL'(i);
        assign clr_w[i]   = bus.clr && bus.clr_sel == WIDTH_SEL'(i);
        voq_cnt_cell #(
            .CNT_WIDTH (CNT_WIDTH),
            .AFULL_TH  (AFULL_TH)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .add_i     (bus.cnt_add[i]),
            .minus_i   (minus_w[i]),
            .clr_i     (clr_w[i]),
            .err_clr_i (bus.err_clr),
            .cnt_o     (cnt_w[i]),
            .eq_zero_o (eq_w[i]),
            .full_o    (full_w[i]),
            .afull_o   (afull_w[i]),
            .ovf_o     (ovf_w[i]),
            .udf_o     (udf_w[i])
        );
    end

    // Readback mux; an unmatched select reads as zero.
    always_comb begin
        rd_cnt_d = '0;
        for (int k = 0; k < PORT_NUB; k++)
            if (bus.rd_sel == WIDTH_SEL'(k)) rd_cnt_d = cnt_w[k];
    end

    // Registered readback of the pre-update count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_cnt_q <= '0;
        else        rd_cnt_q <= rd_cnt_d;
    end

    assign bus.rd_cnt      = rd_cnt_q;
    assign bus.cnt_eq_zero = eq_w;
    assign bus.cnt_full    = full_w;
    assign bus.cnt_afull   = afull_w;
    assign bus.err_ovf     = ovf_w;
    assign bus.err_udf     = udf_w;

endmodule

// File: tb/tb_voq_pkt_cnt_array.sv
// tb_voq_pkt_cnt_array: directed checks of the VOQ counter array in three parameterisations
module tb_voq_pkt_cnt_array;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    voq_pkt_cnt_array_if #(.PORT_NUB(8), .CNT_WIDTH(9)) b0 ();
    voq_pkt_cnt_array_if #(.PORT_NUB(8), .CNT_WIDTH(4)) b1 ();
    voq_pkt_cnt_array_if #(.PORT_NUB(6), .CNT_WIDTH(9)) b2 ();

    voq_pkt_cnt_array #(.PORT_NUB(8), .CNT_WIDTH(9), .AFULL_TH(448)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    voq_pkt_cnt_array #(.PORT_NUB(8), .CNT_WIDTH(4), .AFULL_TH(12))  u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    voq_pkt_cnt_array #(.PORT_NUB(6), .CNT_WIDTH(9), .AFULL_TH(448)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        b0.cnt_add = '0; b0.cnt_minus = 0; b0.minus_sel = '0; b0.clr = 0; b0.clr_sel = '0; b0.err_clr = 0; b0.rd_sel = '0;
        b1.cnt_add = '0; b1.cnt_minus = 0; b1.minus_sel = '0; b1.clr = 0; b1.clr_sel = '0; b1.err_clr = 0; b1.rd_sel = '0;
        b2.cnt_add = '0; b2.cnt_minus = 0; b2.minus_sel = '0; b2.clr = 0; b2.clr_sel = '0; b2.err_clr = 0; b2.rd_sel = '0;
        #22;
        chk("rst_eq_zero", 32'(b0.cnt_eq_zero), 32'hFF);
        chk("rst_full", 32'(b0.cnt_full), 32'h00);
        chk("rst_afull", 32'(b0.cnt_afull), 32'h00);
        chk("rst_rd_cnt", 32'(b0.rd_cnt), 32'h0);
        chk("rst_err", 32'({b0.err_ovf, b0.err_udf}), 32'h0);
        chk("rst_eq_zero_u2", 32'(b2.cnt_eq_zero), 32'h3F);
        tick();
        rst_n = 1'b1;
        // five adds to queue 2
        b0.cnt_add = 8'h04;
        tick(5);
        b0.cnt_add = 8'h00;
        chk("add5_eq_zero", 32'(b0.cnt_eq_zero), 32'hFB);
        b0.rd_sel = 3'd2;
        tick();
        chk("add5_rd_cnt", 32'(b0.rd_cnt), 32'd5);
        // hold at zero on queue 3, then underflow
        b0.cnt_add = 8'h08; b0.cnt_minus = 1; b0.minus_sel = 3'd3;
        tick();
        b0.cnt_add = 8'h00;
        chk("hold0_udf", 32'(b0.err_udf), 32'h00);
        chk("hold0_eq_zero", 32'(b0.cnt_eq_zero), 32'hFB);
        tick();
        b0.cnt_minus = 0;
        chk("udf_set", 32'(b0.err_udf), 32'h08);
        chk("udf_eq_zero", 32'(b0.cnt_eq_zero), 32'hFB);
        b0.rd_sel = 3'd3;
        tick();
        chk("udf_rd_cnt", 32'(b0.rd_cnt), 32'd0);
        // decrement queue 2
        b0.cnt_minus = 1; b0.minus_sel = 3'd2;
        tick();
        b0.cnt_minus = 0; b0.rd_sel = 3'd2;
        tick();
        chk("dec_rd_cnt", 32'(b0.rd_cnt), 32'd4);
        // queue 1 to 7, then clear with a colliding add
        b0.cnt_add = 8'h02;
        tick(7);
        b0.cnt_add = 8'h00; b0.rd_sel = 3'd1;
        tick();
        chk("q1_rd_cnt", 32'(b0.rd_cnt), 32'd7);
        b0.clr = 1; b0.clr_sel = 3'd1; b0.cnt_add = 8'h02;
        tick();
        b0.clr = 0; b0.cnt_add = 8'h00;
        chk("clr_eq_zero", 32'(b0.cnt_eq_zero), 32'hFB);
        chk("clr_ovf", 32'(b0.err_ovf), 32'h00);
        chk("clr_udf", 32'(b0.err_udf), 32'h08);
        tick();
        chk("clr_rd_cnt", 32'(b0.rd_cnt), 32'd0);
        b0.err_clr = 1;
        tick();
        b0.err_clr = 0;
        chk("errclr_udf", 32'(b0.err_udf), 32'h00);
        // concurrent adds to queues 0, 5, 7
        b0.cnt_add = 8'hA1;
        tick(2);
        b0.cnt_add = 8'h00;
        chk("multi_eq_zero", 32'(b0.cnt_eq_zero), 32'h5A);
        b0.rd_sel = 3'd7;
        tick();
        chk("multi_rd_cnt", 32'(b0.rd_cnt), 32'd2);
        // 4-bit counter: afull at 12, full at 15, overflow on 16th
        b1.cnt_add = 8'h01;
        tick(11);
        chk("afull_11", 32'(b1.cnt_afull), 32'h00);
        tick();
        chk("afull_12", 32'(b1.cnt_afull), 32'h01);
        chk("full_12", 32'(b1.cnt_full), 32'h00);
        tick(3);
        chk("full_15", 32'(b1.cnt_full), 32'h01);
        chk("ovf_15", 32'(b1.err_ovf), 32'h00);
        tick();
        chk("ovf_16", 32'(b1.err_ovf), 32'h01);
        b1.err_clr = 1;
        tick();
        chk("ovf_vs_clr", 32'(b1.err_ovf), 32'h01);
        b1.cnt_add = 8'h00;
        tick();
        b1.err_clr = 0;
        chk("ovf_cleared", 32'(b1.err_ovf), 32'h00);
        tick();
        chk("sat_rd_cnt", 32'(b1.rd_cnt), 32'd15);
        // six queues: out-of-range selects ignored
        b2.cnt_add = 6'h20;
        tick(2);
        b2.cnt_add = 6'h00;
        chk("u2_eq_zero", 32'(b2.cnt_eq_zero), 32'h1F);
        b2.cnt_minus = 1; b2.minus_sel = 3'd7; b2.clr = 1; b2.clr_sel = 3'd7; b2.rd_sel = 3'd7;
        tick();
        b2.cnt_minus = 0; b2.clr = 0;
        chk("oor_rd_cnt", 32'(b2.rd_cnt), 32'd0);
        chk("oor_eq_zero", 32'(b2.cnt_eq_zero), 32'h1F);
        chk("oor_udf", 32'(b2.err_udf), 32'h00);
        b2.rd_sel = 3'd5;
        tick();
        chk("oor_rd_q5", 32'(b2.rd_cnt), 32'd2);
        // asynchronous reset mid-operation with a pending add
        b0.cnt_add = 8'h01;
        #2 rst_n = 1'b0;
        #1;
        chk("async_eq_zero", 32'(b0.cnt_eq_zero), 32'hFF);
        chk("async_rd_cnt", 32'(b0.rd_cnt), 32'd0);
        tick();
        chk("async_hold", 32'(b0.cnt_eq_zero), 32'hFF);
        rst_n = 1'b1;
        tick();
        b0.cnt_add = 8'h00;
        chk("post_rst_add", 32'(b0.cnt_eq_zero), 32'hFE);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/voq_pkt_cnt_array.md
VOQ_PKT_CNT_ARRAY -- requirements
Module: voq_pkt_cnt_array

Interface
REQ-001 SHALL have parameter PORT_NUB, default `PORT_NUB_TOTAL (8): number of per-destination queue counters.
REQ-002 SHALL have parameter CNT_WIDTH, default 9: width of each counter; max value CNT_MAX = 2^CNT_WIDTH-1.
REQ-003 SHALL have parameter AFULL_TH, default 448: almost-full threshold, legal range 1..CNT_MAX.
REQ-004 SHALL derive localparam WIDTH_SEL = $clog2(PORT_NUB), minimum 1.
REQ-005 SHALL use reset rst_n, asynchronous, active-low, and clock clk.
REQ-006 Ports:
  clk  in  1  clock.
  rst_n  in  1  async active-low reset.
  cnt_add  in  PORT_NUB  per-queue increment, one packet written.
  cnt_minus  in  1  decrement strobe, one packet read.
  minus_sel  in  WIDTH_SEL  queue targeted by cnt_minus.
  clr  in  1  queue clear strobe.
  clr_sel  in  WIDTH_SEL  queue targeted by clr.
  err_clr  in  1  clear all sticky error bits.
  rd_sel  in  WIDTH_SEL  readback queue select.
  rd_cnt  out  CNT_WIDTH  registered readback count.
  cnt_eq_zero  out  PORT_NUB  queue i empty.
  cnt_full  out  PORT_NUB  queue i at CNT_MAX.
  cnt_afull  out  PORT_NUB  queue i count >= AFULL_TH.
  err_ovf  out  PORT_NUB  sticky: increment attempted at CNT_MAX.
  err_udf  out  PORT_NUB  sticky: decrement attempted at 0.

Function
REQ-007 Per queue i, update at posedge clk with priority: clear > hold > saturate > increment/decrement.
REQ-008 Clear applies when clr && clr_sel==i: cnt <= 0, and same-cycle add/minus to i are discarded without error.
REQ-009 Hold applies when add_i && minus_i, where minus_i = cnt_minus && minus_sel==i: cnt unchanged, no error flagged, even at 0 or CNT_MAX.
REQ-010 Increment applies on add_i only: cnt <= cnt+1 if cnt<CNT_MAX; at CNT_MAX cnt holds and err_ovf[i] sets.
REQ-011 Decrement applies on minus_i only: cnt <= cnt-1 if cnt>0; at 0 cnt holds and err_udf[i] sets.
REQ-012 Counters SHALL never wrap.
REQ-013 Any minus_sel, clr_sel or rd_sel >= PORT_NUB SHALL be ignored: no counter change; rd_cnt <= 0.
REQ-014 cnt_eq_zero, cnt_full and cnt_afull SHALL decode combinationally from registered counters, so they change the cycle after the causing edge.
REQ-015 rd_cnt SHALL be registered with 1-cycle latency: the value at cycle n+1 is the pre-update count of queue rd_sel sampled at cycle n.
REQ-016 Sticky errors: a set condition wins over err_clr in the same cycle, and err_clr clears all other bits.
REQ-017 Multiple cnt_add bits in one cycle SHALL update their queues independently and concurrently.

Reset
REQ-018 On rst_n low, all counters, rd_cnt, err_ovf and err_udf SHALL be 0 immediately; cnt_eq_zero SHALL be all-ones, cnt_full and cnt_afull all-zeros.
REQ-019 Reset asserted mid-operation SHALL discard pending strobes, and the first edge after release SHALL act on inputs normally.

Structure
REQ-020 PORT_NUB_TOTAL and default CNT_WIDTH/AFULL_TH SHALL live in shared generate_parameter.vh; WIDTH_SEL stays local.
REQ-021 One sub-module voq_cnt_cell SHALL hold a single saturating counter with its flags and error bits, instantiated PORT_NUB times in a generate loop; the readback mux and registered rd_cnt sit in the top.

Verification
REQ-022 Reset, then 5 cycles of cnt_add=8'h04 -> cnt[2]=5 and cnt_eq_zero=8'hFB; rd_sel=2 gives rd_cnt=5 one cycle later.
REQ-023 Queue 3 at 0 with cnt_add[3]=1, cnt_minus=1, minus_sel=3 -> cnt[3] stays 0, err_udf[3]=0; then minus alone -> err_udf[3]=1, cnt[3]=0.
REQ-024 With CNT_WIDTH=4 and AFULL_TH=12, 15 adds to queue 0 -> afull rises after the 12th add, full after the 15th; a 16th add -> cnt=15, err_ovf[0]=1.
REQ-025 Queue 1 at 7 with clr, clr_sel=1 and cnt_add[1]=1 -> cnt[1]=0 next cycle, no error.
REQ-026 err_ovf[0] set with err_clr=1 and a new overflow on queue 0 in the same cycle -> err_ovf[0] remains 1; err_clr alone the next cycle -> 0.
REQ-027 PORT_NUB=6 with minus_sel=7 and rd_sel=7 -> no counter changes; rd_cnt=0.
